// File: rtl/fc_mac_seq_if.sv
// Activation-buffer read port and FC MAC control/result bus seen by the FC sequencer.
// The sequencer drives through the master modport; the buffer and MAC datapath use slave.
interface fc_mac_seq_if #(
  parameter int LANES  = 3,
  parameter int ACT_W  = 2,
  parameter int ACC_W  = 10,
  parameter int ADDR_W = 6
);
  logic                          act_avail;
  logic                          act_rd_en;
  logic        [ADDR_W-1:0]      act_rd_addr;
  logic        [LANES*ACT_W-1:0] act_rd_data;
  logic                          mac_clr;
  logic                          mac_en;
  logic        [ADDR_W-1:0]      mac_step;
  logic        [LANES*ACT_W-1:0] mac_lanes;
  logic signed [ACC_W-1:0]       mac_acc0;
  logic signed [ACC_W-1:0]       mac_acc1;

  modport master (
    input  act_avail, act_rd_data, mac_acc0, mac_acc1,
    output act_rd_en, act_rd_addr, mac_clr, mac_en, mac_step, mac_lanes
  );

  modport slave (
    output act_avail, act_rd_data, mac_acc0, mac_acc1,
    input  act_rd_en, act_rd_addr, mac_clr, mac_en, mac_step, mac_lanes
  );
endinterface

// File: rtl/fc_mac_seq.sv
// Sequencer for the BNN VAD fully-connected layer: streams activation words into the
// MAC, then captures both neuron sums and raises a one-cycle done with the decision.
module fc_mac_seq #(
  parameter int N_STEPS = 36,
  parameter int LANES   = 3,
  parameter int ACT_W   = 2,
  parameter int ACC_W   = 10,
  parameter int ADDR_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  fc_mac_seq_if.master            bus,
  output logic                    busy,
  output logic                    done,
  output logic                    vad_flag,
  output logic signed [ACC_W-1:0] score0,
  output logic signed [ACC_W-1:0] score1
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4,
    DECIDE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(N_STEPS - 1);

  state_t                  state_reg;
  logic [ADDR_W-1:0]       step_reg;
  logic [ADDR_W-1:0]       mac_step_reg;
  logic                    mac_clr_reg;
  logic                    mac_en_reg;
  logic                    done_reg;
  logic                    vad_reg;
  logic signed [ACC_W-1:0] score0_reg;
  logic signed [ACC_W-1:0] score1_reg;
  logic [LANES*ACT_W-1:0]  lanes_gated;
  logic                    rd_fire;

  assign rd_fire = (state_reg == RUN) && bus.act_avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      step_reg     <= '0;
      mac_step_reg <= '0;
      mac_clr_reg  <= 1'b0;
      mac_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      vad_reg      <= 1'b0;
      score0_reg   <= '0;
      score1_reg   <= '0;
    end else begin
      mac_clr_reg <= 1'b0;
      done_reg    <= 1'b0;
      // A read issued in the abort cycle must not reach the MAC.
      mac_en_reg  <= rd_fire && !abort;
      if (rd_fire) begin
        mac_step_reg <= step_reg;
      end
      if (abort && (state_reg != IDLE)) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg   <= CLR;
              mac_clr_reg <= 1'b1;
              step_reg    <= '0;
            end
          end
          CLR: state_reg <= RUN;
          RUN: begin
            if (bus.act_avail) begin
              if (step_reg == LAST_STEP) begin
                state_reg <= DRAIN;
              end else begin
                step_reg <= step_reg + 1'b1;
              end
            end
          end
          DRAIN: state_reg <= SETTLE;
          SETTLE: begin
            // Accumulators already hold the last product here, so results are valid with done.
            state_reg  <= DECIDE;
            score0_reg <= bus.mac_acc0;
            score1_reg <= bus.mac_acc1;
            vad_reg    <= ($signed(bus.mac_acc1) > $signed(bus.mac_acc0));
            done_reg   <= 1'b1;
          end
          DECIDE:  state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes_gated[gi*ACT_W +: ACT_W] = mac_en_reg ? bus.act_rd_data[gi*ACT_W +: ACT_W] : '0;
    end
  endgenerate

  assign bus.act_rd_en   = rd_fire;
  assign bus.act_rd_addr = step_reg;
  assign bus.mac_clr     = mac_clr_reg;
  assign bus.mac_en      = mac_en_reg;
  assign bus.mac_step    = mac_step_reg;
  assign bus.mac_lanes   = lanes_gated;

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign vad_flag = vad_reg;
  assign score0   = score0_reg;
  assign score1   = score1_reg;

endmodule

// File: tb/tb_fc_mac_seq.sv
// Directed bench for fc_mac_seq: a registered activation buffer and a simple two-neuron
// MAC surround the sequencer; expected scores and latencies are hand-computed constants.
module tb_fc_mac_seq;
  localparam int N = 36;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;
  logic              vad_flag;
  logic signed [9:0] score0;
  logic signed [9:0] score1;

  fc_mac_seq_if #(.LANES(3), .ACT_W(2), .ACC_W(10), .ADDR_W(6)) bus ();

  fc_mac_seq #(.N_STEPS(N), .LANES(3), .ACT_W(2), .ACC_W(10), .ADDR_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .vad_flag (vad_flag),
    .score0   (score0),
    .score1   (score1)
  );

  always #5 clk = ~clk;

  logic [5:0] mem [0:63];
  int n_checks = 0;
  int n_pass = 0;
  int en_steps[$];
  int lane_err = 0;
  int excl_err = 0;
  int addr_err = 0;

  // Activation buffer: data one cycle after the read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.act_rd_data <= '0;
    else if (bus.act_rd_en) bus.act_rd_data <= mem[bus.act_rd_addr];
  end

  // MAC model: neuron0 += lane0 - lane1, neuron1 += lane2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mac_acc0 <= '0;
      bus.mac_acc1 <= '0;
    end else if (bus.mac_clr) begin
      bus.mac_acc0 <= '0;
      bus.mac_acc1 <= '0;
    end else if (bus.mac_en) begin
      bus.mac_acc0 <= bus.mac_acc0 + 10'(bus.mac_lanes[1:0]) - 10'(bus.mac_lanes[3:2]);
      bus.mac_acc1 <= bus.mac_acc1 + 10'(bus.mac_lanes[5:4]);
    end
  end

  always @(negedge clk) begin
    if (bus.mac_en) begin
      en_steps.push_back(int'(bus.mac_step));
      if (bus.mac_lanes !== mem[bus.mac_step]) lane_err++;
    end
    if ((int'(bus.mac_clr) + int'(bus.mac_en) + int'(done)) > 1) excl_err++;
    if (bus.act_rd_en && (int'(bus.act_rd_addr) > N - 1)) addr_err++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic load_mem(input int which);
    for (int a = 0; a < 64; a++) mem[a] = 6'h00;
    if (which == 1) begin
      for (int a = 0; a < 5; a++) mem[a] = 6'h04;
      mem[10] = 6'h20;
      mem[11] = 6'h20;
      mem[12] = 6'h20;
      mem[13] = 6'h10;
    end else begin
      mem[0]  = 6'h03;
      mem[20] = 6'h05;
      mem[35] = 6'h30;
    end
  endtask

  // Drives one inference starting at cycle 0; reports what it saw each cycle.
  task automatic run_inf(input bit stalls, input int abort_at, input int s_a, input int s_b,
                         input int limit, output int done_cyc, output int n_done,
                         output int busy_late, output int ab_busy, output int ab_en);
    done_cyc = -1;
    n_done = 0;
    busy_late = 0;
    ab_busy = 0;
    ab_en = 0;
    start = 1'b1;
    abort = (abort_at == 0);
    bus.act_avail = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k > done_cyc && busy) busy_late = 1;
      if (k == abort_at + 1) begin
        ab_busy = int'(busy);
        ab_en = int'(bus.mac_en) + int'(done);
      end
      start = (k == s_a) || (k == s_b);
      abort = (k == abort_at);
      bus.act_avail = !(stalls && (k == 2 || k == 3 || k == 21 || k == 22 || k == 41 || k == 42));
    end
    start = 1'b0;
    abort = 1'b0;
    bus.act_avail = 1'b1;
  endtask

  initial begin
    int dc, nd, bl, abb, abe, base, errs;
    bus.act_avail = 1'b1;
    load_mem(1);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_outs", int'(vad_flag) + int'(bus.mac_en) + int'(bus.mac_clr) + int'(bus.act_rd_en), 0);
    check("rst_score0", int'(score0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: plain run, negative vs positive sum
    base = en_steps.size();
    run_inf(1'b0, -1, -1, -1, 50, dc, nd, bl, abb, abe);
    check("t1_done_cycle", dc, 40);
    check("t1_done_count", nd, 1);
    check("t1_en_count", en_steps.size() - base, N);
    check("t1_vad", int'(vad_flag), 1);
    check("t1_score0", int'(score0), -5);
    check("t1_score1", int'(score1), 7);
    $display("run1: done@%0d score0=%0d score1=%0d vad=%0d", dc, score0, score1, vad_flag);

    // 2: tie gives no speech
    load_mem(2);
    run_inf(1'b0, -1, -1, -1, 50, dc, nd, bl, abb, abe);
    check("t2_done_cycle", dc, 40);
    check("t2_vad", int'(vad_flag), 0);
    check("t2_score0", int'(score0), 3);
    check("t2_score1", int'(score1), 3);
    $display("run2: done@%0d score0=%0d score1=%0d vad=%0d", dc, score0, score1, vad_flag);

    // 3: two-cycle stalls at steps 0, 17 and 35
    load_mem(1);
    base = en_steps.size();
    run_inf(1'b1, -1, -1, -1, 60, dc, nd, bl, abb, abe);
    check("t3_done_cycle", dc, 46);
    check("t3_en_count", en_steps.size() - base, N);
    errs = 0;
    for (int i = 0; i < N; i++) begin
      if (base + i >= en_steps.size() || en_steps[base + i] != i) errs++;
    end
    check("t3_step_order", errs, 0);
    check("t3_score0", int'(score0), -5);
    check("t3_score1", int'(score1), 7);
    $display("run3: done@%0d score0=%0d score1=%0d vad=%0d", dc, score0, score1, vad_flag);

    // 4: abort while step 20 is being read
    load_mem(2);
    base = en_steps.size();
    run_inf(1'b0, 22, -1, -1, 60, dc, nd, bl, abb, abe);
    check("t4_no_done", nd, 0);
    check("t4_busy_after_abort", abb, 0);
    check("t4_en_after_abort", abe, 0);
    check("t4_en_count", en_steps.size() - base, 20);
    check("t4_score0_kept", int'(score0), -5);
    check("t4_score1_kept", int'(score1), 7);
    check("t4_vad_kept", int'(vad_flag), 1);
    run_inf(1'b0, -1, -1, -1, 50, dc, nd, bl, abb, abe);
    check("t4_rerun_done", dc, 40);
    check("t4_rerun_score0", int'(score0), 3);
    check("t4_rerun_score1", int'(score1), 3);
    $display("run4: aborted, rerun done@%0d score0=%0d score1=%0d", dc, score0, score1);

    // 5: stray starts in RUN and DECIDE are dropped
    load_mem(1);
    run_inf(1'b0, -1, 10, 40, 70, dc, nd, bl, abb, abe);
    check("t5_done_count", nd, 1);
    check("t5_done_cycle", dc, 40);
    check("t5_no_restart", bl, 0);
    check("t5_score1", int'(score1), 7);
    $display("run5: done@%0d count=%0d restart=%0d", dc, nd, bl);

    // 6: asynchronous reset in the middle of RUN
    load_mem(2);
    run_inf(1'b0, -1, -1, -1, 15, dc, nd, bl, abb, abe);
    check("t6_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_strobes", int'(bus.mac_en) + int'(bus.act_rd_en) + int'(done), 0);
    check("t6_rst_score0", int'(score0), 0);
    check("t6_rst_score1", int'(score1), 0);
    check("t6_rst_addr", int'(bus.act_rd_addr) + int'(bus.mac_step), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_inf(1'b0, -1, -1, -1, 50, dc, nd, bl, abb, abe);
    check("t6_done_cycle", dc, 40);
    check("t6_score0", int'(score0), 3);
    check("t6_score1", int'(score1), 3);
    check("t6_vad", int'(vad_flag), 0);
    $display("run6: done@%0d score0=%0d score1=%0d vad=%0d", dc, score0, score1, vad_flag);

    check("lane_data", lane_err, 0);
    check("strobe_exclusive", excl_err, 0);
    check("addr_bound", addr_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
